// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : wb_regfile
//  Purpose  : Write-back stage and architectural register file.
//             Selects the write-back value from the ALU result or the
//             data-memory read data, commits it to an NREGS x DATA_W
//             register file (register 0 reads as zero), and serves two
//             combinational read ports to decode with write-through bypass.
//             A retire counter tracks the number of effective writes.
//  Ports    : clk, rst_n          - clock, asynchronous active-low reset
//             WB_ALU_RES, WB_DM_Q - candidate write-back values
//             WB_RF_D_SEL         - 0 selects ALU result, 1 selects memory data
//             WB_RF_WE, WB_RF_WA  - write enable and destination address
//             ID_RS_A, ID_RT_A    - read addresses (ports A and B)
//             ID_RS_Q, ID_RT_Q    - read data (combinational, bypassed)
//             WB_RF_D             - selected write-back data (combinational)
//             WB_COMMIT           - registered pulse after an effective write
//             WB_RETIRE_CNT       - registered effective-write count (wraps)
//  Revision : 1.0 - initial release
// ============================================================================
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] WB_ALU_RES,
    input  logic [DATA_W-1:0] WB_DM_Q,
    input  logic              WB_RF_D_SEL,
    input  logic              WB_RF_WE,
    input  logic [ADDR_W-1:0] WB_RF_WA,
    input  logic [ADDR_W-1:0] ID_RS_A,
    input  logic [ADDR_W-1:0] ID_RT_A,
    output logic [DATA_W-1:0] ID_RS_Q,
    output logic [DATA_W-1:0] ID_RT_Q,
    output logic [DATA_W-1:0] WB_RF_D,
    output logic              WB_COMMIT,
    output logic [CNT_W-1:0]  WB_RETIRE_CNT
);

    logic [DATA_W-1:0] rf_q [NREGS];
    logic              wr_eff;
    logic              commit_q;
    logic              commit_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    // Write-back data mux, also forwarded to EX.
    assign WB_RF_D = WB_RF_D_SEL ? WB_DM_Q : WB_ALU_RES;

    // A write to r0 is not a write at all. While reset is held nothing
    // is in flight, so the bypass must not present the discarded value.
    assign wr_eff = rst_n & WB_RF_WE & (WB_RF_WA != '0);

    // Register array. Entry 0 is reset and never written (wr_eff excludes
    // address 0), so it stays a constant zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wr_eff) begin
            rf_q[WB_RF_WA] <= WB_RF_D;
        end
    end

    // Read port A: zero register, then same-cycle bypass, then array.
    always_comb begin
        ID_RS_Q = rf_q[ID_RS_A];
        if (ID_RS_A == '0) begin
            ID_RS_Q = '0;
        end else if (wr_eff && (WB_RF_WA == ID_RS_A)) begin
            ID_RS_Q = WB_RF_D;
        end
    end

    // Read port B resolves independently of port A.
    always_comb begin
        ID_RT_Q = rf_q[ID_RT_A];
        if (ID_RT_A == '0) begin
            ID_RT_Q = '0;
        end else if (wr_eff && (WB_RF_WA == ID_RT_A)) begin
            ID_RT_Q = WB_RF_D;
        end
    end

    // Commit pulse and retire counter next state. The counter wraps
    // naturally at CNT_W bits.
    always_comb begin
        commit_d = wr_eff;
        cnt_d    = cnt_q;
        if (wr_eff) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            commit_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            commit_q <= commit_d;
            cnt_q    <= cnt_d;
        end
    end

    assign WB_COMMIT     = commit_q;
    assign WB_RETIRE_CNT = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_regfile
//  Purpose  : Self-checking bench for wb_regfile. Drives directed write-back
//             and read sequences into a full-width instance and a 4-bit
//             counter instance sharing the same stimulus; expected commit
//             and counter values are queued at stimulus time and checked
//             after each clock edge, reads are checked against a bench model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] alu, dm;
    logic        sel, we;
    logic [4:0]  wa, ra, rb;

    logic [31:0] rs_q, rt_q, wbd, cnt;
    logic        commit;
    logic [31:0] rs4, rt4, wbd4;
    logic        commit4;
    logic [3:0]  cnt4;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk(clk), .rst_n(rst_n), .WB_ALU_RES(alu), .WB_DM_Q(dm),
        .WB_RF_D_SEL(sel), .WB_RF_WE(we), .WB_RF_WA(wa),
        .ID_RS_A(ra), .ID_RT_A(rb), .ID_RS_Q(rs_q), .ID_RT_Q(rt_q),
        .WB_RF_D(wbd), .WB_COMMIT(commit), .WB_RETIRE_CNT(cnt)
    );

    wb_regfile #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .WB_ALU_RES(alu), .WB_DM_Q(dm),
        .WB_RF_D_SEL(sel), .WB_RF_WE(we), .WB_RF_WA(wa),
        .ID_RS_A(ra), .ID_RT_A(rb), .ID_RS_Q(rs4), .ID_RT_Q(rt4),
        .WB_RF_D(wbd4), .WB_COMMIT(commit4), .WB_RETIRE_CNT(cnt4)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] model [32];
    logic [31:0] cnt_m;

    typedef struct {
        logic        commit;
        logic [31:0] cnt;
        logic [3:0]  cnt4;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wbd_m();
        return sel ? dm : alu;
    endfunction

    function automatic logic [31:0] rd_m(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (rst_n && we && (wa == a)) return wbd_m();
        return model[a];
    endfunction

    task automatic drive(input logic w, input logic [4:0] a, input logic [31:0] al,
                         input logic [31:0] d, input logic s);
        we = w; wa = a; alu = al; dm = d; sel = s;
    endtask

    // Push expectation for the coming edge, clock, then pop and compare.
    task automatic tick();
        exp_t        e;
        logic        eff = we && (wa != 5'd0);
        logic [31:0] d   = wbd_m();
        logic [4:0]  a   = wa;
        if (eff) cnt_m = cnt_m + 32'd1;
        e.commit = eff;
        e.cnt    = cnt_m;
        e.cnt4   = cnt_m[3:0];
        sb.push_back(e);
        @(posedge clk);
        if (eff) model[a] = d;
        #1;
        e = sb.pop_front();
        chk("commit",  {31'd0, commit},  {31'd0, e.commit});
        chk("commit4", {31'd0, commit4}, {31'd0, e.commit});
        chk("cnt",     cnt,              e.cnt);
        chk("cnt4",    {28'd0, cnt4},    {28'd0, e.cnt4});
    endtask

    task automatic rd(input logic [4:0] a, input logic [4:0] b, input string tag);
        ra = a; rb = b;
        #1;
        chk({tag, ".rs"},  rs_q, rd_m(a));
        chk({tag, ".rt"},  rt_q, rd_m(b));
        chk({tag, ".rs4"}, rs4,  rd_m(a));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        cnt_m = 32'd0;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
        ra = 5'd0; rb = 5'd0;

        // Initial reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_commit", {31'd0, commit}, 32'd0);
        chk("rst_cnt",    cnt,             32'd0);
        chk("rst_cnt4",   {28'd0, cnt4},   32'd0);
        rd(5'd5, 5'd31, "rst_rd");
        rst_n = 1'b1;

        // Select ALU result, commit to r5
        drive(1'b1, 5'd5, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0);
        #1 chk("wbd_alu", wbd, 32'h1234_5678);
        tick();
        drive(1'b0, 5'd5, 32'h0, 32'h0, 1'b0);
        rd(5'd5, 5'd5, "sel0");
        chk("sel0_lit", rs_q, 32'h1234_5678);
        tick();

        // Select memory data, commit to r6
        drive(1'b1, 5'd6, 32'h1234_5678, 32'hDEAD_BEEF, 1'b1);
        #1 chk("wbd_dm", wbd, 32'hDEAD_BEEF);
        tick();
        drive(1'b0, 5'd6, 32'h1, 32'h2, 1'b0);
        rd(5'd6, 5'd5, "sel1");
        chk("sel1_lit", rs_q, 32'hDEAD_BEEF);
        chk("cnt_after2", cnt, 32'd2);

        // Select changes between edges reach WB_RF_D immediately
        #1 chk("wbd_mid0", wbd, 32'h1);
        sel = 1'b1;
        #1 chk("wbd_mid1", wbd, 32'h2);
        tick();

        // Write-through bypass on both ports, then from the array
        drive(1'b1, 5'd7, 32'hA5A5_A5A5, 32'h0, 1'b0);
        rd(5'd7, 5'd7, "byp_pre");
        chk("byp_pre_lit", rt_q, 32'hA5A5_A5A5);
        tick();
        drive(1'b0, 5'd7, 32'h0, 32'h0, 1'b0);
        rd(5'd7, 5'd7, "byp_post");
        chk("byp_post_lit", rs_q, 32'hA5A5_A5A5);

        // Writes to r0 are dropped and not counted
        drive(1'b1, 5'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        rd(5'd0, 5'd0, "r0_pre");
        tick();
        drive(1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
        rd(5'd0, 5'd0, "r0_post");

        // WE=0 leaves the target untouched and does not bypass
        drive(1'b1, 5'd3, 32'h0000_0033, 32'h0, 1'b0);
        tick();
        drive(1'b0, 5'd3, 32'h0000_0BAD, 32'h0, 1'b0);
        rd(5'd3, 5'd3, "we0_pre");
        tick();
        rd(5'd3, 5'd3, "we0_post");
        chk("we0_lit", rs_q, 32'h0000_0033);

        // 32 back-to-back writes: r1..r31 then r1 again
        for (int i = 0; i < 32; i++) begin
            logic [4:0] a;
            a = (i < 31) ? 5'(i + 1) : 5'd1;
            drive(1'b1, a, 32'h100 + 32'(a), 32'h0, 1'b0);
            tick();
        end
        drive(1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
        for (int a = 0; a < 32; a++) begin
            rd(5'(a), 5'(31 - a), "b2b");
        end
        ra = 5'd1; rb = 5'd31;
        #1;
        chk("b2b_r1",  rs_q, 32'h0000_0101);
        chk("b2b_r31", rt_q, 32'h0000_011F);

        // Asynchronous reset mid-cycle with a write in flight
        drive(1'b1, 5'd9, 32'h0000_9999, 32'h0, 1'b0);
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_commit", {31'd0, commit}, 32'd0);
        chk("arst_cnt",    cnt,             32'd0);
        chk("arst_cnt4",   {28'd0, cnt4},   32'd0);
        cnt_m = 32'd0;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        for (int a = 0; a < 32; a++) begin
            ra = 5'(a); rb = 5'(31 - a);
            #1;
            chk("arst_rs", rs_q, 32'd0);
            chk("arst_rt", rt_q, 32'd0);
        end
        @(posedge clk);
        #1;
        chk("arst_hold_cnt", cnt, 32'd0);
        ra = 5'd9;
        #1 chk("arst_hold_r9", rs_q, 32'd0);
        drive(1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
        rst_n = 1'b1;

        // Counter wrap on the 4-bit instance: ...15 -> 0 -> 1
        for (int k = 0; k < 17; k++) begin
            drive(1'b1, 5'((k % 31) + 1), 32'(k), 32'h0, 1'b0);
            tick();
            if (k == 14) chk("wrap15", {28'd0, cnt4}, 32'd15);
            if (k == 15) chk("wrap0",  {28'd0, cnt4}, 32'd0);
        end
        chk("wrap1",     {28'd0, cnt4}, 32'd1);
        chk("wrap_full", cnt,           32'd17);
        drive(1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
